teng_rx_pkt_checker: RTL and testbench

- Synthesizable receive-side packet checker on the teng_mac RX AXIS-style stream.
- It is the hardware reader that pairs with the packet writer driving the MAC TX stream.
- It verifies the loopback traffic pattern (length increments by one per packet, incrementing-byte payload) and counts good and bad packets.
- It sits directly on rx_data_o/rx_vldb_o/rx_valid_o/rx_last_o/rx_user_o of teng_mac in on-board loopback builds.

---
 rtl/teng_chk_pkg.sv | 28 ++
 rtl/teng_sat_cnt.sv | 33 +++
 rtl/teng_rx_pkt_checker.sv | 196 +++++++++++++++++++
 tb/tb_teng_rx_pkt_checker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/teng_chk_pkg.sv
// Shared types and constants for the teng_mac RX loopback packet checker.
// The LFSR constants are only used when TENG_RX_CHK_BACKPRESSURE_EN is defined.
package teng_chk_pkg;

  typedef enum logic {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } chk_state_e;

  localparam int unsigned MIN_LEN_DEF = 60;
  localparam int unsigned MAX_LEN_DEF = 1514;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] lane_mask(input logic [1:0] vldb);
    logic [3:0] m;
    case (vldb)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/teng_sat_cnt.sv
// Saturating statistics counter with synchronous clear (clear has priority).
module teng_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/teng_rx_pkt_checker.sv
// Receive-side checker for the teng_mac loopback pattern (length +1 per packet,
// incrementing-byte payload). Define TENG_RX_CHK_BACKPRESSURE_EN for LFSR stalls.
//
// state   | meaning
// ST_SOP  | waiting for the first beat of a packet; lane 0 becomes the payload seed
// ST_BODY | mid-packet; lanes compared against the running expected byte
module teng_rx_pkt_checker
  import teng_chk_pkg::*;
#(
  parameter int unsigned MIN_LEN = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             rx_user_clk_i,
  input  logic             rx_user_rst_i,
  input  logic [31:0]      rx_data_i,
  input  logic [1:0]       rx_vldb_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  input  logic             rx_last_i,
  input  logic             rx_user_i,
  input  logic             chk_clr_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] len_err_cnt_o,
  output logic [CNT_W-1:0] data_err_cnt_o,
  output logic [CNT_W-1:0] crc_err_cnt_o,
  output logic             err_pulse_o,
  output logic [15:0]      last_len_o
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  chk_state_e  state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  exp_byte_q, exp_byte_d;
  logic        data_bad_q, data_bad_d;
  logic [15:0] exp_len_q, exp_len_d;
  logic        locked_q, locked_d;
  logic [15:0] last_len_q, last_len_d;
  logic        err_pulse_q, err_pulse_d;

  logic        ready;
  logic        beat, eop;
  logic [3:0]  mask;
  logic [2:0]  nbytes;
  logic [7:0]  base;
  logic        mismatch;
  logic        bad_data;
  logic [15:0] pkt_len;
  logic        len_in_range, len_err;
  logic        inc_good, inc_len, inc_data, inc_crc;

`ifdef TENG_RX_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
    if (rx_user_rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ready = (lfsr_q[1:0] != 2'b00);
`else
  assign ready = 1'b1;
`endif

  assign beat = rx_valid_i & ready;
  assign eop  = beat & rx_last_i;

  // Per-beat datapath: lane compare against seed (SOP) or running expected byte
  always_comb begin
    mask     = rx_last_i ? lane_mask(rx_vldb_i) : 4'hF;
    nbytes   = rx_last_i ? ({1'b0, rx_vldb_i} + 3'd1) : 3'd4;
    base     = (state_q == ST_SOP) ? rx_data_i[7:0] : exp_byte_q;
    mismatch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && (rx_data_i[8*i +: 8] != (base + 8'(i)))) begin
        mismatch = 1'b1;
      end
    end
    bad_data     = (state_q == ST_SOP) ? mismatch : (data_bad_q | mismatch);
    pkt_len      = ((state_q == ST_SOP) ? 16'd0 : byte_cnt_q) + {13'd0, nbytes};
    len_in_range = (pkt_len >= MIN_L) && (pkt_len <= MAX_L);
    len_err      = !rx_user_i && (!len_in_range || (locked_q && (pkt_len != exp_len_q)));
  end

  // One counter per packet: crc > length > data > good; a coincident clear drops it
  assign inc_crc  = eop && !chk_clr_i && rx_user_i;
  assign inc_len  = eop && !chk_clr_i && len_err;
  assign inc_data = eop && !chk_clr_i && !rx_user_i && !len_err && bad_data;
  assign inc_good = eop && !chk_clr_i && !rx_user_i && !len_err && !bad_data;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    exp_byte_d  = exp_byte_q;
    data_bad_d  = data_bad_q;
    exp_len_d   = exp_len_q;
    locked_d    = locked_q;
    last_len_d  = last_len_q;
    err_pulse_d = 1'b0;

    if (beat) begin
      byte_cnt_d = pkt_len;
      exp_byte_d = base + {5'd0, nbytes};
      data_bad_d = bad_data;
      case (state_q)
        ST_SOP:  state_d = rx_last_i ? ST_SOP : ST_BODY;
        ST_BODY: state_d = rx_last_i ? ST_SOP : ST_BODY;
        default: state_d = ST_SOP;
      endcase
    end

    if (eop) begin
      last_len_d  = pkt_len;
      err_pulse_d = rx_user_i | len_err | bad_data;
      // Always re-sync to the received length so one drop costs one error
      exp_len_d   = (pkt_len >= MAX_L) ? MIN_L : (pkt_len + 16'd1);
      if (!rx_user_i && len_in_range) begin
        locked_d = 1'b1;
      end
    end

    if (chk_clr_i) begin
      locked_d    = 1'b0;
      last_len_d  = 16'd0;
      err_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
    if (rx_user_rst_i) begin
      state_q     <= ST_SOP;
      byte_cnt_q  <= 16'd0;
      exp_byte_q  <= 8'd0;
      data_bad_q  <= 1'b0;
      exp_len_q   <= MIN_L;
      locked_q    <= 1'b0;
      last_len_q  <= 16'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      exp_byte_q  <= exp_byte_d;
      data_bad_q  <= data_bad_d;
      exp_len_q   <= exp_len_d;
      locked_q    <= locked_d;
      last_len_q  <= last_len_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  teng_sat_cnt #(.CNT_W(CNT_W)) u_good_cnt (
    .clk_i (rx_user_clk_i),
    .rst_i (rx_user_rst_i),
    .clr_i (chk_clr_i),
    .inc_i (inc_good),
    .cnt_o (good_cnt_o)
  );

  teng_sat_cnt #(.CNT_W(CNT_W)) u_len_err_cnt (
    .clk_i (rx_user_clk_i),
    .rst_i (rx_user_rst_i),
    .clr_i (chk_clr_i),
    .inc_i (inc_len),
    .cnt_o (len_err_cnt_o)
  );

  teng_sat_cnt #(.CNT_W(CNT_W)) u_data_err_cnt (
    .clk_i (rx_user_clk_i),
    .rst_i (rx_user_rst_i),
    .clr_i (chk_clr_i),
    .inc_i (inc_data),
    .cnt_o (data_err_cnt_o)
  );

  teng_sat_cnt #(.CNT_W(CNT_W)) u_crc_err_cnt (
    .clk_i (rx_user_clk_i),
    .rst_i (rx_user_rst_i),
    .clr_i (chk_clr_i),
    .inc_i (inc_crc),
    .cnt_o (crc_err_cnt_o)
  );

  assign rx_ready_o  = ready;
  assign locked_o    = locked_q;
  assign last_len_o  = last_len_q;
  assign err_pulse_o = err_pulse_q;

endmodule

// File: tb/tb_teng_rx_pkt_checker.sv
// Directed self-checking bench for teng_rx_pkt_checker; the source holds each
// beat while rx_ready_o is low, so it also covers TENG_RX_CHK_BACKPRESSURE_EN builds.
module tb_teng_rx_pkt_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data_i;
  logic [1:0]  rx_vldb_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        rx_last_i;
  logic        rx_user_i;
  logic        chk_clr_i;
  logic        locked_o;
  logic [31:0] good_cnt_o;
  logic [31:0] len_err_cnt_o;
  logic [31:0] data_err_cnt_o;
  logic [31:0] crc_err_cnt_o;
  logic        err_pulse_o;
  logic [15:0] last_len_o;

  int n_vec = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int mon_cycles = 0;
  int mon_low = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cycles++;
      if (!rx_ready_o) mon_low++;
    end
  end

  teng_rx_pkt_checker dut (
    .rx_user_clk_i  (clk),
    .rx_user_rst_i  (rst),
    .rx_data_i      (rx_data_i),
    .rx_vldb_i      (rx_vldb_i),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .rx_last_i      (rx_last_i),
    .rx_user_i      (rx_user_i),
    .chk_clr_i      (chk_clr_i),
    .locked_o       (locked_o),
    .good_cnt_o     (good_cnt_o),
    .len_err_cnt_o  (len_err_cnt_o),
    .data_err_cnt_o (data_err_cnt_o),
    .crc_err_cnt_o  (crc_err_cnt_o),
    .err_pulse_o    (err_pulse_o),
    .last_len_o     (last_len_o)
  );

  // Sends one packet; p1/p2 are err_pulse_o one and two cycles after the last beat.
  task automatic send_pkt(input int len, input logic [7:0] seed, input int bad_off,
                          input logic user, input logic clr_last,
                          output logic p1, output logic p2);
    int nbeats;
    int off;
    int guard;
    logic [31:0] d;
    logic [7:0] v;
    logic last;
    nbeats = (len + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < 4; l++) begin
        off = b * 4 + l;
        v = seed + 8'(off);
        if (off == bad_off) v = v ^ 8'h01;
        d[8*l +: 8] = (off < len) ? v : 8'h00;
      end
      last       = (b == nbeats - 1);
      rx_data_i  = d;
      rx_valid_i = 1'b1;
      rx_last_i  = last;
      rx_vldb_i  = last ? 2'((len - 1) % 4) : 2'd0;
      rx_user_i  = last ? user : 1'b0;
      chk_clr_i  = last ? clr_last : 1'b0;
      guard = 0;
      while (!rx_ready_o) begin
        stall_cnt++;
        guard++;
        if (guard > 1000) begin
          n_err++;
          $display("FAIL ready_timeout: rx_ready_o stuck at 0 for %0d cycles, need 1", guard);
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
          $fatal(1, "ready timeout");
        end
        @(negedge clk);
      end
      @(negedge clk);
    end
    p1 = err_pulse_o;
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
    rx_user_i  = 1'b0;
    rx_vldb_i  = 2'd0;
    chk_clr_i  = 1'b0;
    @(negedge clk);
    p2 = err_pulse_o;
  endtask

  task automatic do_clear();
    chk_clr_i = 1'b1;
    @(negedge clk);
    chk_clr_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data_i = 32'd0; rx_vldb_i = 2'd0; rx_valid_i = 1'b0;
    rx_last_i = 1'b0; rx_user_i = 1'b0; chk_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", rx_ready_o); end
    n_vec++;
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b want 0", locked_o); end
    n_vec++;
    if ({good_cnt_o, len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o} !== 128'd0) begin
      n_err++; $display("FAIL rst_counters: got %0d/%0d/%0d/%0d want 0/0/0/0",
                        good_cnt_o, len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o);
    end
    n_vec++;
    if ({err_pulse_o, last_len_o} !== 17'd0) begin
      n_err++; $display("FAIL rst_pulse_len: got pulse %b len %0d want 0 0", err_pulse_o, last_len_o);
    end
  endtask

  task automatic test_sequence();
    logic p1, p2;
    int pulses;
    pulses = 0;
    stall_cnt = 0;
    for (int n = 60; n < 160; n++) begin
      send_pkt(n, 8'($urandom_range(0, 255)), -1, 1'b0, 1'b0, p1, p2);
      if (p1 || p2) pulses++;
    end
    n_vec++;
    if (good_cnt_o !== 32'd100) begin n_err++; $display("FAIL seq_good: got %0d want 100", good_cnt_o); end
    n_vec++;
    if ({len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o} !== 96'd0) begin
      n_err++; $display("FAIL seq_errs: got %0d/%0d/%0d want 0/0/0", len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o);
    end
    n_vec++;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL seq_locked: got %b want 1", locked_o); end
    n_vec++;
    if (last_len_o !== 16'd159) begin n_err++; $display("FAIL seq_last_len: got %0d want 159", last_len_o); end
    n_vec++;
    if (pulses !== 0) begin n_err++; $display("FAIL seq_pulses: got %0d want 0", pulses); end
`ifndef TENG_RX_CHK_BACKPRESSURE_EN
    n_vec++;
    if (stall_cnt !== 0) begin n_err++; $display("FAIL seq_ready_const: stalls %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_drop();
    logic p1, p2;
    do_clear();
    n_vec++;
    if ({good_cnt_o, locked_o, last_len_o} !== 49'd0) begin
      n_err++; $display("FAIL clr_state: got good %0d locked %b len %0d want 0 0 0", good_cnt_o, locked_o, last_len_o);
    end
    send_pkt(60, 8'h10, -1, 1'b0, 1'b0, p1, p2);
    send_pkt(61, 8'h20, -1, 1'b0, 1'b0, p1, p2);
    send_pkt(63, 8'h30, -1, 1'b0, 1'b0, p1, p2);
    n_vec++;
    if ({p1, p2} !== 2'b10) begin n_err++; $display("FAIL drop_pulse: got %b%b want 10", p1, p2); end
    send_pkt(64, 8'h40, -1, 1'b0, 1'b0, p1, p2);
    n_vec++;
    if (p1 !== 1'b0) begin n_err++; $display("FAIL drop_resync_pulse: got %b want 0", p1); end
    n_vec++;
    if (len_err_cnt_o !== 32'd1) begin n_err++; $display("FAIL drop_len_err: got %0d want 1", len_err_cnt_o); end
    n_vec++;
    if (good_cnt_o !== 32'd3) begin n_err++; $display("FAIL drop_good: got %0d want 3", good_cnt_o); end
  endtask

  task automatic test_data_err();
    logic p1, p2;
    do_clear();
    send_pkt(97, 8'hF0, 50, 1'b0, 1'b0, p1, p2);
    n_vec++;
    if (data_err_cnt_o !== 32'd1) begin n_err++; $display("FAIL data_err_cnt: got %0d want 1", data_err_cnt_o); end
    n_vec++;
    if ({p1, p2} !== 2'b10) begin n_err++; $display("FAIL data_pulse: got %b%b want 10", p1, p2); end
    n_vec++;
    if ({good_cnt_o, len_err_cnt_o} !== 64'd0) begin
      n_err++; $display("FAIL data_others: got good %0d len %0d want 0 0", good_cnt_o, len_err_cnt_o);
    end
    n_vec++;
    if (last_len_o !== 16'd97) begin n_err++; $display("FAIL data_last_len: got %0d want 97", last_len_o); end
  endtask

  task automatic test_crc();
    logic p1, p2;
    do_clear();
    send_pkt(70, 8'h05, -1, 1'b0, 1'b0, p1, p2);
    send_pkt(71, 8'h80, 33, 1'b1, 1'b0, p1, p2);
    n_vec++;
    if (crc_err_cnt_o !== 32'd1) begin n_err++; $display("FAIL crc_cnt: got %0d want 1", crc_err_cnt_o); end
    n_vec++;
    if (data_err_cnt_o !== 32'd0) begin n_err++; $display("FAIL crc_data_cnt: got %0d want 0", data_err_cnt_o); end
    n_vec++;
    if (p1 !== 1'b1) begin n_err++; $display("FAIL crc_pulse: got %b want 1", p1); end
    send_pkt(72, 8'hFE, -1, 1'b0, 1'b0, p1, p2);
    n_vec++;
    if ({good_cnt_o, len_err_cnt_o} !== {32'd2, 32'd0}) begin
      n_err++; $display("FAIL crc_next_good: got good %0d len %0d want 2 0", good_cnt_o, len_err_cnt_o);
    end
  endtask

  task automatic test_wrap_clear();
    logic p1, p2;
    do_clear();
    send_pkt(1513, 8'h33, -1, 1'b0, 1'b0, p1, p2);
    send_pkt(1514, 8'h44, -1, 1'b0, 1'b0, p1, p2);
    send_pkt(60, 8'h55, -1, 1'b0, 1'b0, p1, p2);
    n_vec++;
    if (good_cnt_o !== 32'd3) begin n_err++; $display("FAIL wrap_good: got %0d want 3", good_cnt_o); end
    n_vec++;
    if (len_err_cnt_o !== 32'd0) begin n_err++; $display("FAIL wrap_len_err: got %0d want 0", len_err_cnt_o); end
    n_vec++;
    if (last_len_o !== 16'd60) begin n_err++; $display("FAIL wrap_last_len: got %0d want 60", last_len_o); end
    send_pkt(61, 8'h66, -1, 1'b0, 1'b1, p1, p2);
    n_vec++;
    if ({good_cnt_o, len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o} !== 128'd0) begin
      n_err++; $display("FAIL eop_clr_counters: got %0d/%0d/%0d/%0d want 0/0/0/0",
                        good_cnt_o, len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o);
    end
    n_vec++;
    if ({locked_o, last_len_o} !== 17'd0) begin
      n_err++; $display("FAIL eop_clr_lock: got locked %b len %0d want 0 0", locked_o, last_len_o);
    end
  endtask

`ifdef TENG_RX_CHK_BACKPRESSURE_EN
  task automatic test_backpressure();
    logic p1, p2;
    do_clear();
    mon_cycles = 0;
    mon_low = 0;
    mon_en = 1'b1;
    for (int n = 100; n < 150; n++) begin
      send_pkt(n, 8'($urandom_range(0, 255)), -1, 1'b0, 1'b0, p1, p2);
    end
    mon_en = 1'b0;
    n_vec++;
    if (good_cnt_o !== 32'd50) begin n_err++; $display("FAIL bp_good: got %0d want 50", good_cnt_o); end
    n_vec++;
    if ({len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o} !== 96'd0) begin
      n_err++; $display("FAIL bp_errs: got %0d/%0d/%0d want 0/0/0", len_err_cnt_o, data_err_cnt_o, crc_err_cnt_o);
    end
    n_vec++;
    if (mon_low * 10 < mon_cycles) begin
      n_err++; $display("FAIL bp_stall_ratio: low %0d of %0d cycles, need >= 10%%", mon_low, mon_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_drop();
    test_data_err();
    test_crc();
    test_wrap_clear();
`ifdef TENG_RX_CHK_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
